usr_axis_rr_scheduler: RTL and testbench
========================================

Name: usr_axis_rr_scheduler

Overview:
- Packet-granular round-robin arbiter that shares one AXI4-Stream master output between two stream requesters (s0, s1).
- Sits in front of the DMA S2MM stream input, alongside the stream master/slave interfaces of the user IP.
- Locks the grant for a whole packet, enforces a maximum packet length by forcing TLAST, and keeps per-source packet counters readable by the AXI-Lite register block.

Parameters:
- C_AXIS_TDATA_WIDTH, 32: data width of all stream ports; strobe width is C_AXIS_TDATA_WIDTH/8.
- C_MAX_PKT_BEATS, 256: maximum beats per output packet, range 2..65535. The beat that reaches this limit carries a forced TLAST.

Ports:
- axis_aclk  in  1  single clock for all logic.
- axis_areset  in  1  asynchronous, active-high reset.
- en  in  1  arbitration enable; level-sensitive.
- s0_axis_tvalid / s0_axis_tready / s0_axis_tlast  in/out/in  1  requester 0 handshake and end of packet.
- s0_axis_tdata / s0_axis_tstrb  in  C_AXIS_TDATA_WIDTH / C_AXIS_TDATA_WIDTH/8  requester 0 payload.
- s1_axis_tvalid / s1_axis_tready / s1_axis_tlast / s1_axis_tdata / s1_axis_tstrb  as s0, for requester 1.
- m_axis_tvalid / m_axis_tlast  out  1  output stream valid and end of packet.
- m_axis_tdata / m_axis_tstrb  out  C_AXIS_TDATA_WIDTH / C_AXIS_TDATA_WIDTH/8  output payload.
- m_axis_tready  in  1  downstream ready.
- grant  out  2  one-hot current owner: 01 = s0, 10 = s1, 00 = idle.
- pkt_cnt0, pkt_cnt1  out  16  packets forwarded per source; wrap at 16 bits.
- trunc  out  1  one-cycle pulse when a TLAST is forced.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, grant = 00, pkt_cnt0/1 = 0, trunc = 0, beat_cnt = 0.
  - last_grant = s1, so s0 wins the first arbitration.
  - m_axis_tvalid, m_axis_tlast and both s*_axis_tready are 0.
  - m_axis_tdata and m_axis_tstrb are 0.
- States: IDLE, BUSY0, BUSY1.
- IDLE:
  - All s*_tready = 0; m_axis_tvalid = 0.
  - If en = 1 and any tvalid is high, grant the source that is not last_grant if its tvalid is high; otherwise grant the other.
  - Move to BUSY0/BUSY1 on the next edge. No beat transfers in the IDLE cycle (arbitration latency 1 cycle).
- BUSYx (combinational pass-through, zero-cycle data latency):
  - m_axis_tvalid = sx_tvalid; m_axis_tdata/tstrb = sx data/strb; sx_tready = m_axis_tready.
  - The non-granted tready = 0.
  - m_axis_tlast = sx_tlast OR (beat_cnt == C_MAX_PKT_BEATS-1).
- Beat handshake (m_axis_tvalid AND m_axis_tready):
  - Non-final beat: beat_cnt += 1.
  - Final beat (m_axis_tlast = 1): beat_cnt <= 0, pkt_cnt_x += 1, last_grant <= x, state <= IDLE.
- Truncation:
  - Applies when the final beat has sx_tlast = 0: trunc pulses in the cycle after that handshake.
  - The source's remaining beats are not dropped; they form a new packet that competes in the next arbitration.
- en deasserted mid-packet: the current packet completes normally; no new grant while en = 0.
- Grant stability:
  - Grant never changes within a packet, including while tvalid is low (gaps) or tready is low (backpressure).
  - A source that drops tvalid mid-packet keeps the grant.
- Both sources request continuously: grants alternate strictly packet by packet.
- Counter wrap: pkt_cnt 0xFFFF + 1 = 0x0000, with no flag.
- Reset asserted mid-packet: immediate return to reset values. The partial packet is abandoned with no TLAST emitted; the downstream must tolerate this.

Test Plan:
- Reset, then en = 1, s0 sends 4 beats (tlast on beat 4), m_axis_tready = 1 -> grant = 01 one cycle after tvalid; 4 output beats match data; pkt_cnt0 = 1; grant returns to 00.
- Both sources hold 3-beat packets continuously for 4 packets -> output order s0, s1, s0, s1; pkt_cnt0 = pkt_cnt1 = 2; no interleaving of beats within a packet.
- C_MAX_PKT_BEATS = 4, s1 sends 6 beats with tlast on beat 6 -> output packets of 4 (forced TLAST) and 2 beats; trunc pulses once; pkt_cnt1 = 2.
- m_axis_tready toggles randomly during an s0 packet while s1 requests -> s1_tready stays 0 throughout; data is intact with no duplicated or lost beats; grant stays 01 until TLAST.
- en goes 0 on beat 2 of a 5-beat s0 packet -> packet completes with 5 beats; with en held at 0, s1 is never granted; raising en grants s1 after 1 cycle.
- Assert axis_areset mid-packet -> all outputs are 0 asynchronously; after release, arbitration restarts with s0 priority.

Source files
------------

// File: rtl/usr_axis_rr_scheduler.sv
// usr_axis_rr_scheduler
// Packet-granular round-robin arbiter sharing one AXI4-Stream master between
// two requesters. The grant is held for a whole packet, packets longer than
// C_MAX_PKT_BEATS get a forced TLAST, and per-source packet counts are kept.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no owner; arbitrate among valid requesters (no beat this cycle)
// BUSY0 | s0 owns the output, combinational pass-through until final beat
// BUSY1 | s1 owns the output, combinational pass-through until final beat
module usr_axis_rr_scheduler #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int C_MAX_PKT_BEATS    = 256
) (
  input  logic                            axis_aclk,
  input  logic                            axis_areset,
  input  logic                            en,
  input  logic                            s0_axis_tvalid,
  output logic                            s0_axis_tready,
  input  logic                            s0_axis_tlast,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s0_axis_tstrb,
  input  logic                            s1_axis_tvalid,
  output logic                            s1_axis_tready,
  input  logic                            s1_axis_tlast,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s1_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s1_axis_tstrb,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tstrb,
  input  logic                            m_axis_tready,
  output logic [1:0]                      grant,
  output logic [15:0]                     pkt_cnt0,
  output logic [15:0]                     pkt_cnt1,
  output logic                            trunc
);

  localparam logic [15:0] LAST_BEAT = 16'(C_MAX_PKT_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;   // 0 = s0 served last, 1 = s1 served last
  logic [15:0] beat_cnt;
  logic        at_limit;
  logic        src_last;
  logic        beat_xfer;
  logic        pkt_done;

  assign at_limit = (beat_cnt == LAST_BEAT);

  // Arbitration, next-state and the pass-through mux for the granted source
  always_comb begin
    state_nxt      = state;
    grant          = 2'b00;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tstrb   = '0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    src_last       = 1'b0;
    case (state)
      IDLE: begin
        if (en && (s0_axis_tvalid || s1_axis_tvalid)) begin
          if (last_grant)
            state_nxt = s0_axis_tvalid ? BUSY0 : BUSY1;
          else
            state_nxt = s1_axis_tvalid ? BUSY1 : BUSY0;
        end
      end
      BUSY0: begin
        grant          = 2'b01;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tstrb   = s0_axis_tstrb;
        src_last       = s0_axis_tlast;
        m_axis_tlast   = s0_axis_tlast | at_limit;
        s0_axis_tready = m_axis_tready;
      end
      BUSY1: begin
        grant          = 2'b10;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tstrb   = s1_axis_tstrb;
        src_last       = s1_axis_tlast;
        m_axis_tlast   = s1_axis_tlast | at_limit;
        s1_axis_tready = m_axis_tready;
      end
      default: state_nxt = IDLE;
    endcase
    beat_xfer = m_axis_tvalid & m_axis_tready;
    pkt_done  = beat_xfer & m_axis_tlast;
    if (pkt_done)
      state_nxt = IDLE;
  end

  // State, beat counter, round-robin pointer, packet counters, truncation pulse
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
      pkt_cnt0   <= '0;
      pkt_cnt1   <= '0;
      trunc      <= 1'b0;
    end else begin
      state <= state_nxt;
      trunc <= 1'b0;
      if (beat_xfer) begin
        if (m_axis_tlast) begin
          beat_cnt <= '0;
          // A forced TLAST leaves the rest of the source packet queued; it
          // re-enters arbitration as a fresh packet.
          trunc    <= ~src_last;
          if (state == BUSY0) begin
            pkt_cnt0   <= pkt_cnt0 + 16'd1;
            last_grant <= 1'b0;
          end else begin
            pkt_cnt1   <= pkt_cnt1 + 16'd1;
            last_grant <= 1'b1;
          end
        end else begin
          beat_cnt <= beat_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_usr_axis_rr_scheduler.sv
// Testbench for usr_axis_rr_scheduler: a vector table for single-cycle
// behaviour plus queue-driven sequences for multi-packet corner cases.
module tb_usr_axis_rr_scheduler;

  localparam int DW   = 32;
  localparam int MAXB = 6;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          s0_v, s0_r, s0_l;
  logic [DW-1:0] s0_d;
  logic [3:0]    s0_s;
  logic          s1_v, s1_r, s1_l;
  logic [DW-1:0] s1_d;
  logic [3:0]    s1_s;
  logic          m_v, m_l, m_r;
  logic [DW-1:0] m_d;
  logic [3:0]    m_s;
  logic [1:0]    grant;
  logic [15:0]   pkt0, pkt1;
  logic          trunc;

  int errors = 0;
  int checks = 0;

  usr_axis_rr_scheduler #(.C_AXIS_TDATA_WIDTH(DW), .C_MAX_PKT_BEATS(MAXB)) dut (
    .axis_aclk(clk), .axis_areset(rst), .en(en),
    .s0_axis_tvalid(s0_v), .s0_axis_tready(s0_r), .s0_axis_tlast(s0_l),
    .s0_axis_tdata(s0_d), .s0_axis_tstrb(s0_s),
    .s1_axis_tvalid(s1_v), .s1_axis_tready(s1_r), .s1_axis_tlast(s1_l),
    .s1_axis_tdata(s1_d), .s1_axis_tstrb(s1_s),
    .m_axis_tvalid(m_v), .m_axis_tlast(m_l), .m_axis_tdata(m_d),
    .m_axis_tstrb(m_s), .m_axis_tready(m_r),
    .grant(grant), .pkt_cnt0(pkt0), .pkt_cnt1(pkt1), .trunc(trunc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst, en, v0, l0; logic [31:0] d0;
    logic v1, l1; logic [31:0] d1; logic mr;
    logic e_mv, e_ml; logic [31:0] e_md; logic [1:0] e_g;
    logic e_r0, e_r1; logic [15:0] e_p0, e_p1; logic e_tr;
  } vec_t;

  function automatic vec_t mk(input logic rst_i, en_i, v0, l0, input logic [31:0] d0,
                              input logic v1, l1, input logic [31:0] d1, input logic mr,
                              input logic mv, ml, input logic [31:0] md, input logic [1:0] g,
                              input logic r0, r1, input logic [15:0] p0, p1, input logic tr);
    vec_t v;
    v.rst = rst_i; v.en = en_i; v.v0 = v0; v.l0 = l0; v.d0 = d0;
    v.v1 = v1; v.l1 = l1; v.d1 = d1; v.mr = mr;
    v.e_mv = mv; v.e_ml = ml; v.e_md = md; v.e_g = g;
    v.e_r0 = r0; v.e_r1 = r1; v.e_p0 = p0; v.e_p1 = p1; v.e_tr = tr;
    return v;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [1:0] g);
    return (g == 2'b01) ? 4'hF : (g == 2'b10) ? 4'h3 : 4'h0;
  endfunction

  typedef struct { logic [31:0] d; logic l; } beat_t;
  typedef struct { logic [1:0] g; logic [31:0] d; logic l; } obs_t;

  beat_t q0[$], q1[$];
  obs_t  log_q[$], exp_q[$];
  int    ready_bad, switch_bad, grant_while_off;

  function automatic logic [31:0] bdata(input int src, input int tag, input int beat);
    return {4'(src), 4'h0, 8'(tag), 16'(beat)};
  endfunction

  task automatic push_pkt(input int src, input int tag, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = bdata(src, tag, i);
      b.l = (i == n - 1);
      if (src == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  task automatic add_exp(input int src, input int tag, input int n);
    obs_t o;
    for (int i = 0; i < n; i++) begin
      o.g = (src == 0) ? 2'b01 : 2'b10;
      o.d = bdata(src, tag, i);
      o.l = (i == n - 1);
      exp_q.push_back(o);
    end
  endtask

  task automatic cmp_log(input string name);
    chk({name, "_beats"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      chk({name, "_beat"}, {29'd0, log_q[i].g, log_q[i].d, log_q[i].l},
          {29'd0, exp_q[i].g, exp_q[i].d, exp_q[i].l});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b0; m_r = 1'b1;
    s0_v = 1'b0; s0_l = 1'b0; s0_d = '0;
    s1_v = 1'b0; s1_l = 1'b0; s1_d = '0;
    q0.delete(); q1.delete(); log_q.delete(); exp_q.delete();
    ready_bad = 0; switch_bad = 0; grant_while_off = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drive both sources from their queues, log every output handshake and
  // watch the grant/ready invariants until the selected queues are drained.
  task automatic run(input int max_cyc, input bit rnd_ready, input int en_off_after,
                     input bit stop_q0_only);
    int n = 0;
    int s0_beats = 0;
    logic [1:0] prev_grant = 2'b00;
    logic prev_final = 1'b0;
    logic prev_en = en;
    logic fin;
    obs_t o;
    forever begin
      @(posedge clk); #1;
      s0_v = (q0.size() > 0);
      if (s0_v) begin s0_d = q0[0].d; s0_l = q0[0].l; end
      else begin s0_d = '0; s0_l = 1'b0; end
      s1_v = (q1.size() > 0);
      if (s1_v) begin s1_d = q1[0].d; s1_l = q1[0].l; end
      else begin s1_d = '0; s1_l = 1'b0; end
      m_r = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (en_off_after >= 0 && s0_beats >= en_off_after) en = 1'b0;
      @(negedge clk);
      if (q0.size() == 0 && (stop_q0_only || q1.size() == 0) && grant == 2'b00) break;
      if (n >= max_cyc) begin
        checks++; errors++;
        $display("FAIL run_timeout: got %0d cycles required drain within %0d", n, max_cyc);
        break;
      end
      if ((grant == 2'b01 && s1_r) || (grant == 2'b10 && s0_r) || (grant == 2'b00 && (s0_r || s1_r)))
        ready_bad++;
      if (prev_grant != 2'b00 && grant != prev_grant && !prev_final) switch_bad++;
      if (grant != 2'b00 && prev_grant == 2'b00 && !prev_en) grant_while_off++;
      fin = m_v && m_r && m_l;
      if (m_v && m_r) begin
        o.g = grant; o.d = m_d; o.l = m_l;
        log_q.push_back(o);
      end
      if (s0_v && s0_r) begin void'(q0.pop_front()); s0_beats++; end
      if (s1_v && s1_r) void'(q1.pop_front());
      prev_grant = grant; prev_final = fin; prev_en = en;
      n++;
    end
  endtask

  vec_t vt[$];

  initial begin
    rst = 1'b1; en = 1'b0; m_r = 1'b0;
    s0_v = 1'b0; s0_l = 1'b0; s0_d = '0; s0_s = 4'hF;
    s1_v = 1'b0; s1_l = 1'b0; s1_d = '0; s1_s = 4'h3;

    // rst,en,v0,l0,d0, v1,l1,d1, mr | mv,ml,md,g, r0,r1, p0,p1, tr
    vt.push_back(mk(H,L,L,L,32'h0,         L,L,32'h0,         L, L,L,32'h0,         2'b00, L,L, 16'd0,16'd0, L));
    vt.push_back(mk(L,H,H,L,32'hA000_0000, L,L,32'h0,         H, L,L,32'h0,         2'b00, L,L, 16'd0,16'd0, L));
    vt.push_back(mk(L,H,H,L,32'hA000_0000, L,L,32'h0,         H, H,L,32'hA000_0000, 2'b01, H,L, 16'd0,16'd0, L));
    vt.push_back(mk(L,H,H,L,32'hA000_0001, L,L,32'h0,         H, H,L,32'hA000_0001, 2'b01, H,L, 16'd0,16'd0, L));
    vt.push_back(mk(L,H,H,L,32'hA000_0002, L,L,32'h0,         L, H,L,32'hA000_0002, 2'b01, L,L, 16'd0,16'd0, L));
    vt.push_back(mk(L,H,H,L,32'hA000_0002, L,L,32'h0,         H, H,L,32'hA000_0002, 2'b01, H,L, 16'd0,16'd0, L));
    vt.push_back(mk(L,H,H,H,32'hA000_0003, L,L,32'h0,         H, H,H,32'hA000_0003, 2'b01, H,L, 16'd0,16'd0, L));
    vt.push_back(mk(L,H,L,L,32'h0,         L,L,32'h0,         H, L,L,32'h0,         2'b00, L,L, 16'd1,16'd0, L));
    vt.push_back(mk(L,H,L,L,32'h0,         H,L,32'hB000_0000, H, L,L,32'h0,         2'b00, L,L, 16'd1,16'd0, L));
    vt.push_back(mk(L,H,L,L,32'h0,         H,L,32'hB000_0000, H, H,L,32'hB000_0000, 2'b10, L,H, 16'd1,16'd0, L));
    vt.push_back(mk(L,H,L,L,32'h0,         H,L,32'hB000_0001, H, H,L,32'hB000_0001, 2'b10, L,H, 16'd1,16'd0, L));
    vt.push_back(mk(L,H,L,L,32'h0,         L,L,32'h0,         H, L,L,32'h0,         2'b10, L,H, 16'd1,16'd0, L));
    vt.push_back(mk(L,H,L,L,32'h0,         H,L,32'hB000_0002, H, H,L,32'hB000_0002, 2'b10, L,H, 16'd1,16'd0, L));
    vt.push_back(mk(L,H,L,L,32'h0,         H,L,32'hB000_0003, H, H,L,32'hB000_0003, 2'b10, L,H, 16'd1,16'd0, L));
    vt.push_back(mk(L,H,L,L,32'h0,         H,L,32'hB000_0004, H, H,L,32'hB000_0004, 2'b10, L,H, 16'd1,16'd0, L));
    vt.push_back(mk(L,H,L,L,32'h0,         H,L,32'hB000_0005, H, H,H,32'hB000_0005, 2'b10, L,H, 16'd1,16'd0, L));
    vt.push_back(mk(L,H,L,L,32'h0,         H,L,32'hB000_0006, H, L,L,32'h0,         2'b00, L,L, 16'd1,16'd1, H));
    vt.push_back(mk(L,H,L,L,32'h0,         H,L,32'hB000_0006, H, H,L,32'hB000_0006, 2'b10, L,H, 16'd1,16'd1, L));
    vt.push_back(mk(L,H,L,L,32'h0,         H,H,32'hB000_0007, H, H,H,32'hB000_0007, 2'b10, L,H, 16'd1,16'd1, L));
    vt.push_back(mk(L,H,L,L,32'h0,         L,L,32'h0,         H, L,L,32'h0,         2'b00, L,L, 16'd1,16'd2, L));

    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk); #1;
      rst = vt[i].rst; en = vt[i].en;
      s0_v = vt[i].v0; s0_l = vt[i].l0; s0_d = vt[i].d0;
      s1_v = vt[i].v1; s1_l = vt[i].l1; s1_d = vt[i].d1;
      m_r = vt[i].mr;
      @(negedge clk);
      chk($sformatf("v%0d_mvalid", i), 64'(m_v),   64'(vt[i].e_mv));
      chk($sformatf("v%0d_mlast", i),  64'(m_l),   64'(vt[i].e_ml));
      chk($sformatf("v%0d_mdata", i),  64'(m_d),   64'(vt[i].e_md));
      chk($sformatf("v%0d_mstrb", i),  64'(m_s),   64'(exp_strb(vt[i].e_g)));
      chk($sformatf("v%0d_grant", i),  64'(grant), 64'(vt[i].e_g));
      chk($sformatf("v%0d_s0rdy", i),  64'(s0_r),  64'(vt[i].e_r0));
      chk($sformatf("v%0d_s1rdy", i),  64'(s1_r),  64'(vt[i].e_r1));
      chk($sformatf("v%0d_pkt0", i),   64'(pkt0),  64'(vt[i].e_p0));
      chk($sformatf("v%0d_pkt1", i),   64'(pkt1),  64'(vt[i].e_p1));
      chk($sformatf("v%0d_trunc", i),  64'(trunc), 64'(vt[i].e_tr));
    end

    // Both sources request continuously: strict packet alternation.
    do_reset();
    en = 1'b1;
    push_pkt(0, 1, 3); push_pkt(0, 2, 3);
    push_pkt(1, 1, 3); push_pkt(1, 2, 3);
    add_exp(0, 1, 3); add_exp(1, 1, 3); add_exp(0, 2, 3); add_exp(1, 2, 3);
    run(200, 1'b0, -1, 1'b0);
    cmp_log("alt");
    chk("alt_pkt0", 64'(pkt0), 64'd2);
    chk("alt_pkt1", 64'(pkt1), 64'd2);
    chk("alt_ready_excl", 64'(ready_bad), 64'd0);
    chk("alt_grant_lock", 64'(switch_bad), 64'd0);

    // Random backpressure during an s0 packet while s1 waits.
    do_reset();
    en = 1'b1;
    push_pkt(0, 3, 5); push_pkt(1, 3, 3);
    add_exp(0, 3, 5); add_exp(1, 3, 3);
    run(400, 1'b1, -1, 1'b0);
    cmp_log("bp");
    chk("bp_ready_excl", 64'(ready_bad), 64'd0);
    chk("bp_grant_lock", 64'(switch_bad), 64'd0);
    chk("bp_pkt0", 64'(pkt0), 64'd1);
    chk("bp_pkt1", 64'(pkt1), 64'd1);

    // en dropped mid-packet: packet completes, no new grant until en returns.
    do_reset();
    en = 1'b1;
    push_pkt(0, 4, 5); push_pkt(1, 4, 3);
    add_exp(0, 4, 5);
    run(200, 1'b0, 2, 1'b1);
    cmp_log("enoff");
    chk("enoff_pkt0", 64'(pkt0), 64'd1);
    chk("enoff_no_grant", 64'(grant_while_off), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("enoff_idle_grant", 64'(grant), 64'd0);
    end
    @(posedge clk); #1;
    en = 1'b1;
    @(negedge clk);
    chk("enon_arb_cycle", 64'(grant), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("enon_grant_s1", 64'(grant), 64'h2);
    chk("enon_data", 64'(m_d), 64'(bdata(1, 4, 0)));

    // Reset mid-packet after an s0 packet: everything clears, s0 wins again.
    do_reset();
    en = 1'b1;
    push_pkt(0, 5, 1);
    run(50, 1'b0, -1, 1'b0);
    chk("rst_pre_pkt0", 64'(pkt0), 64'd1);
    @(posedge clk); #1;
    s0_v = 1'b1; s0_l = 1'b0; s0_d = 32'hC000_0000; m_r = 1'b1;
    @(negedge clk);
    chk("rst_pre_idle", 64'(grant), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pre_busy", {62'd0, grant}, 64'h1);
    @(posedge clk); #1;
    s0_d = 32'hC000_0001;
    @(negedge clk);
    chk("rst_pre_data", 64'(m_d), 64'hC000_0001);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_outs", {19'd0, m_v, m_l, m_d, m_s, grant, s0_r, s1_r, trunc, 3'd0}, 64'd0);
    chk("rst_async_pkt0", 64'(pkt0), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    s1_v = 1'b1; s1_l = 1'b0; s1_d = 32'hD000_0000;
    @(negedge clk);
    chk("rst_post_idle", 64'(grant), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_post_s0_first", 64'(grant), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
